// File: rtl/obuffer_unpack.sv
// Egress unpacker: buffers two-slot packed words in a DEPTH-entry FIFO and replays them as an
// Avalon-ST flit stream. Optional flit statistics are enabled with `define OBUFFER_UNPACK_STATS_EN.
module obuffer_unpack #(
  parameter int PACKET_WIDTH = 142,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  input  logic [PACKET_WIDTH-1:0] i_data,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic                    o_sop,
  output logic                    o_eop,
  output logic [2:0]              o_empty,
  output logic                    o_error,
  output logic [DATA_WIDTH-1:0]   o_data,
  input  logic                    i_ready
`ifdef OBUFFER_UNPACK_STATS_EN
  ,
  output logic [31:0]             o_pkt_count,
  output logic [15:0]             o_err_count
`endif
);

  localparam int HALF  = PACKET_WIDTH / 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO} state_t;

  logic [PACKET_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        mem_count_reg, count;
  logic [PACKET_WIDTH-1:0] head_reg;
  logic                    head_valid_reg;
  logic                    push, mem_rd, head_pop, accept;

  state_t                  state_reg, state_next;
  logic [PACKET_WIDTH-1:0] word_reg;
  logic [HALF-1:0]         hi_slot, lo_slot, cur_slot;

  // The head register makes the FIFO first-word-fall-through while the array keeps a registered read.
  assign count   = mem_count_reg + CNT_W'(head_valid_reg);
  assign o_ready = (count < DEPTH_C);
  assign push    = i_valid && o_ready;
  assign mem_rd  = (mem_count_reg != '0) && (!head_valid_reg || head_pop);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= i_data;
    if (mem_rd)
      head_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_count_reg  <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (mem_rd)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, mem_rd})
        2'b10:   mem_count_reg <= mem_count_reg + 1'b1;
        2'b01:   mem_count_reg <= mem_count_reg - 1'b1;
        default: mem_count_reg <= mem_count_reg;
      endcase
      if (mem_rd)
        head_valid_reg <= 1'b1;
      else if (head_pop)
        head_valid_reg <= 1'b0;
    end
  end

  assign hi_slot  = word_reg[PACKET_WIDTH-1:HALF];
  assign lo_slot  = word_reg[HALF-1:0];
  assign cur_slot = (state_reg == ST_LO) ? lo_slot : hi_slot;

  // A word whose HI valid bit is clear never raises o_valid, so it is dropped silently.
  assign o_valid = (state_reg != ST_IDLE) && cur_slot[HALF-1];
  assign o_sop   = o_valid & cur_slot[HALF-2];
  assign o_eop   = o_valid & cur_slot[HALF-3];
  assign o_empty = o_valid ? cur_slot[HALF-4:HALF-6] : 3'd0;
  assign o_error = o_valid & cur_slot[HALF-7];
  assign o_data  = o_valid ? cur_slot[DATA_WIDTH-1:0] : '0;
  assign accept  = o_valid && i_ready;

  always_comb begin
    state_next = state_reg;
    head_pop   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (head_valid_reg) begin
          head_pop   = 1'b1;
          state_next = ST_HI;
        end
      end
      ST_HI: begin
        if (!hi_slot[HALF-1] || accept) begin
          if (hi_slot[HALF-1] && lo_slot[HALF-1]) begin
            state_next = ST_LO;
          end else if (head_valid_reg) begin
            head_pop   = 1'b1;
            state_next = ST_HI;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_LO: begin
        if (accept) begin
          if (head_valid_reg) begin
            head_pop   = 1'b1;
            state_next = ST_HI;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (head_pop)
        word_reg <= head_reg;
    end
  end

`ifdef OBUFFER_UNPACK_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_pkt_count <= '0;
      o_err_count <= '0;
    end else begin
      if (accept && o_eop && (o_pkt_count != '1))
        o_pkt_count <= o_pkt_count + 32'd1;
      if (accept && o_error && (o_err_count != '1))
        o_err_count <= o_err_count + 16'd1;
    end
  end
`endif

endmodule
